// File: rtl/jogo_pkg.sv
// Shared game definitions: FSM and frame sub-step encodings, screen and start constants,
// and the per-axis motion helpers used by the ball engine.
package jogo_pkg;

  typedef enum logic [1:0] {ESPERA = 2'd0, JOGANDO = 2'd1, PERDEU = 2'd2} estado_e;
  typedef enum logic [1:0] {OCIOSO = 2'd0, MOVE = 2'd1, CHECK = 2'd2} passo_e;

  localparam int H_TELA = 640;
  localparam int V_TELA = 480;

  localparam logic [9:0] X_ALIADA_INI  = 10'd300;
  localparam logic [9:0] Y_ALIADA_INI  = 10'd300;
  localparam logic [9:0] X_INIMIGA_INI = 10'd500;
  localparam logic [9:0] Y_INIMIGA_INI = 10'd100;

  typedef struct packed {
    logic [9:0]        pos;
    logic signed [3:0] vel;
  } eixo_t;

  function automatic logic [9:0] satura(input logic signed [10:0] v,
                                        input logic signed [10:0] lo,
                                        input logic signed [10:0] hi);
    logic [9:0] r;
    if (v < lo) r = lo[9:0];
    else if (v > hi) r = hi[9:0];
    else r = v[9:0];
    return r;
  endfunction

  // Opposite keys cancel; the signed 11-bit sum exposes underflow before the clamp.
  function automatic logic [9:0] move_aliada(input logic [9:0] pos,
                                             input logic mais, input logic menos,
                                             input logic signed [10:0] passo,
                                             input logic signed [10:0] lo,
                                             input logic signed [10:0] hi);
    logic signed [10:0] prox;
    prox = $signed({1'b0, pos});
    if (mais && !menos) prox = prox + passo;
    else if (menos && !mais) prox = prox - passo;
    else prox = prox;
    return satura(prox, lo, hi);
  endfunction

  function automatic eixo_t rebate(input logic [9:0] pos, input logic signed [3:0] vel,
                                   input logic signed [10:0] lo,
                                   input logic signed [10:0] hi);
    eixo_t r;
    logic signed [10:0] prox;
    prox = $signed({1'b0, pos}) + $signed({{7{vel[3]}}, vel});
    if (prox < lo) begin
      r.pos = lo[9:0];
      r.vel = -vel;
    end else if (prox > hi) begin
      r.pos = hi[9:0];
      r.vel = -vel;
    end else begin
      r.pos = prox[9:0];
      r.vel = vel;
    end
    return r;
  endfunction

  function automatic logic signed [3:0] acelera(input logic signed [3:0] v);
    logic signed [3:0] r;
    if (v >= 4'sd4 || v <= -4'sd4) r = v;
    else if (v < 4'sd0) r = v - 4'sd1;
    else r = v + 4'sd1;
    return r;
  endfunction

endpackage

// File: rtl/controle_bolas_if.sv
// Ball state bundle from the game engine (master) to the renderer (slave).
interface controle_bolas_if;
  logic [9:0]  x_bola_aliada;
  logic [9:0]  y_bola_aliada;
  logic [9:0]  raio_bola_aliada;
  logic [9:0]  x_bola_inimiga;
  logic [9:0]  y_bola_inimiga;
  logic [9:0]  raio_bola_inimiga;
  logic        perdeu;
  logic [15:0] pontos;

  modport master (output x_bola_aliada, y_bola_aliada, raio_bola_aliada,
                  output x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
                  output perdeu, pontos);
  modport slave  (input x_bola_aliada, y_bola_aliada, raio_bola_aliada,
                  input x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
                  input perdeu, pontos);
endinterface

// File: rtl/colisao_circ.sv
// Circle overlap test: squared centre distance against squared radius sum, registered hit.
module colisao_circ (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] xa,
  input  logic [9:0] ya,
  input  logic [9:0] ra,
  input  logic [9:0] xb,
  input  logic [9:0] yb,
  input  logic [9:0] rb,
  output logic       hit
);
  logic [9:0]  dx, dy;
  logic [20:0] dist2;
  logic [10:0] soma_r;
  logic [21:0] lim2;
  logic        hit_d, hit_q;

  // Touching circles (distance equal to radius sum) count as a hit.
  always_comb begin
    dx     = (xa >= xb) ? (xa - xb) : (xb - xa);
    dy     = (ya >= yb) ? (ya - yb) : (yb - ya);
    dist2  = 21'(dx) * 21'(dx) + 21'(dy) * 21'(dy);
    soma_r = 11'(ra) + 11'(rb);
    lim2   = 22'(soma_r) * 22'(soma_r);
    hit_d  = (22'(dist2) <= lim2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= 1'b0;
    else hit_q <= hit_d;
  end

  assign hit = hit_q;
endmodule

// File: rtl/controle_bolas.sv
// Per-frame ball engine: allied motion from keys, bouncing enemy, collision and score.
// Optional enemy acceleration every 512 frames is built when ACELERA_INIMIGA_EN is defined.
module controle_bolas
  import jogo_pkg::*;
#(
  parameter int H_ATIVO       = H_TELA,
  parameter int V_ATIVO       = V_TELA,
  parameter int RAIO          = 5,
  parameter int PASSO_ALIADA  = 2,
  parameter int PASSO_INIMIGA = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [3:0]       keysout,
  input  logic [9:0]       VGA_X,
  input  logic [9:0]       VGA_Y,
  controle_bolas_if.master bolas
);
  localparam logic signed [10:0] MIN_POS = 11'(RAIO);
  localparam logic signed [10:0] X_MAX   = 11'(H_ATIVO - 1 - RAIO);
  localparam logic signed [10:0] Y_MAX   = 11'(V_ATIVO - 1 - RAIO);
  localparam logic signed [10:0] PASSO_A = 11'(PASSO_ALIADA);
  localparam logic signed [3:0]  VEL_INI = 4'(PASSO_INIMIGA);
  localparam logic [9:0]         RAIO_V  = 10'(RAIO);

  estado_e           estado_q, estado_d;
  passo_e            passo_q, passo_d;
  logic              vblank_q, vblank_d, vblank_ant_q, vblank_ant_d, tick_q, tick_d;
  logic              tecla_q, tecla_d, borda_tecla;
  logic [9:0]        xa_q, xa_d, ya_q, ya_d, xi_q, xi_d, yi_q, yi_d;
  logic signed [3:0] vx_q, vx_d, vy_q, vy_d;
  logic              perdeu_q, perdeu_d;
  logic [15:0]       pontos_q, pontos_d;
  logic              hit;
  logic [9:0]        xa_mov, ya_mov;
  eixo_t             ex, ey;
`ifdef ACELERA_INIMIGA_EN
  logic [8:0]        quadros_q, quadros_d;
`endif

  colisao_circ u_colisao (
    .clk(CLOCK_50), .rst_n(reset),
    .xa(xa_q), .ya(ya_q), .ra(RAIO_V),
    .xb(xi_q), .yb(yi_q), .rb(RAIO_V),
    .hit(hit)
  );

  // Frame tick, key edge and candidate next positions.
  always_comb begin
    vblank_d     = (VGA_X == 10'd0) && (VGA_Y == 10'(V_ATIVO));
    vblank_ant_d = vblank_q;
    tick_d       = vblank_q && !vblank_ant_q;
    tecla_d      = |keysout;
    borda_tecla  = tecla_d && !tecla_q;
    xa_mov       = move_aliada(xa_q, keysout[0], keysout[1], PASSO_A, MIN_POS, X_MAX);
    ya_mov       = move_aliada(ya_q, keysout[2], keysout[3], PASSO_A, MIN_POS, Y_MAX);
    ex           = rebate(xi_q, vx_q, MIN_POS, X_MAX);
    ey           = rebate(yi_q, vy_q, MIN_POS, Y_MAX);
  end

  // Game FSM with the MOVE/CHECK frame sub-sequence.
  always_comb begin
    estado_d = estado_q;
    passo_d  = passo_q;
    xa_d     = xa_q;
    ya_d     = ya_q;
    xi_d     = xi_q;
    yi_d     = yi_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    perdeu_d = perdeu_q;
    pontos_d = pontos_q;
`ifdef ACELERA_INIMIGA_EN
    quadros_d = quadros_q;
`endif
    case (estado_q)
      ESPERA: begin
        if (borda_tecla) estado_d = JOGANDO;
        else estado_d = ESPERA;
      end
      JOGANDO: begin
        case (passo_q)
          OCIOSO: begin
            if (tick_q) begin
              passo_d = MOVE;
              xa_d    = xa_mov;
              ya_d    = ya_mov;
              xi_d    = ex.pos;
              vx_d    = ex.vel;
              yi_d    = ey.pos;
              vy_d    = ey.vel;
            end else begin
              passo_d = OCIOSO;
            end
          end
          MOVE: passo_d = CHECK;
          CHECK: begin
            passo_d = OCIOSO;
            if (hit) begin
              estado_d = PERDEU;
              perdeu_d = 1'b1;
            end else begin
              if (pontos_q != 16'hFFFF) pontos_d = pontos_q + 16'd1;
              else pontos_d = pontos_q;
`ifdef ACELERA_INIMIGA_EN
              quadros_d = quadros_q + 9'd1;
              if (quadros_q == 9'd511) begin
                vx_d = acelera(vx_q);
                vy_d = acelera(vy_q);
              end else begin
                vx_d = vx_q;
                vy_d = vy_q;
              end
`endif
            end
          end
          default: passo_d = OCIOSO;
        endcase
      end
      PERDEU: begin
        if (borda_tecla) begin
          estado_d = ESPERA;
          passo_d  = OCIOSO;
          xa_d     = X_ALIADA_INI;
          ya_d     = Y_ALIADA_INI;
          xi_d     = X_INIMIGA_INI;
          yi_d     = Y_INIMIGA_INI;
          vx_d     = VEL_INI;
          vy_d     = -VEL_INI;
          perdeu_d = 1'b0;
          pontos_d = 16'd0;
`ifdef ACELERA_INIMIGA_EN
          quadros_d = 9'd0;
`endif
        end else begin
          estado_d = PERDEU;
        end
      end
      default: begin
        estado_d = ESPERA;
        passo_d  = OCIOSO;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      vblank_q     <= 1'b0;
      vblank_ant_q <= 1'b0;
      tick_q       <= 1'b0;
      tecla_q      <= 1'b0;
      estado_q     <= ESPERA;
      passo_q      <= OCIOSO;
      xa_q         <= X_ALIADA_INI;
      ya_q         <= Y_ALIADA_INI;
      xi_q         <= X_INIMIGA_INI;
      yi_q         <= Y_INIMIGA_INI;
      vx_q         <= VEL_INI;
      vy_q         <= -VEL_INI;
      perdeu_q     <= 1'b0;
      pontos_q     <= 16'd0;
`ifdef ACELERA_INIMIGA_EN
      quadros_q    <= 9'd0;
`endif
    end else begin
      vblank_q     <= vblank_d;
      vblank_ant_q <= vblank_ant_d;
      tick_q       <= tick_d;
      tecla_q      <= tecla_d;
      estado_q     <= estado_d;
      passo_q      <= passo_d;
      xa_q         <= xa_d;
      ya_q         <= ya_d;
      xi_q         <= xi_d;
      yi_q         <= yi_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      perdeu_q     <= perdeu_d;
      pontos_q     <= pontos_d;
`ifdef ACELERA_INIMIGA_EN
      quadros_q    <= quadros_d;
`endif
    end
  end

  assign bolas.x_bola_aliada     = xa_q;
  assign bolas.y_bola_aliada     = ya_q;
  assign bolas.raio_bola_aliada  = RAIO_V;
  assign bolas.x_bola_inimiga    = xi_q;
  assign bolas.y_bola_inimiga    = yi_q;
  assign bolas.raio_bola_inimiga = RAIO_V;
  assign bolas.perdeu            = perdeu_q;
  assign bolas.pontos            = pontos_q;
endmodule

// File: tb/tb_controle_bolas.sv
// Directed bench for controle_bolas: an integer per-frame game model checked once per frame,
// plus hand-computed literal expectations at key points of the scenario.
module tb_controle_bolas;
  localparam int R = 5;
  localparam int XMAX = 640 - 1 - R;
  localparam int YMAX = 480 - 1 - R;

  logic       clk;
  logic       reset;
  logic [3:0] keysout;
  logic [9:0] VGA_X, VGA_Y;
  logic       amostra;

  controle_bolas_if bolas ();

  controle_bolas dut (
    .CLOCK_50(clk), .reset(reset), .keysout(keysout),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .bolas(bolas)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int erros  = 0;
  int mxa, mya, mxi, myi, mvx, mvy, mest, mpontos, mperdeu;

  task automatic cmp(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      erros++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic modelo_inicio();
    mxa = 300; mya = 300; mxi = 500; myi = 100;
    mvx = 1; mvy = -1; mest = 0; mpontos = 0; mperdeu = 0;
  endtask

  function automatic int lim(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // One frame of game rules applied to the model.
  task automatic modelo_quadro();
    int d2;
    if (mest == 1) begin
      if (keysout[0] && !keysout[1]) mxa += 2;
      else if (keysout[1] && !keysout[0]) mxa -= 2;
      if (keysout[2] && !keysout[3]) mya += 2;
      else if (keysout[3] && !keysout[2]) mya -= 2;
      mxa = lim(mxa, R, XMAX);
      mya = lim(mya, R, YMAX);
      mxi += mvx;
      if (mxi < R || mxi > XMAX) begin mxi = lim(mxi, R, XMAX); mvx = -mvx; end
      myi += mvy;
      if (myi < R || myi > YMAX) begin myi = lim(myi, R, YMAX); mvy = -mvy; end
      d2 = (mxa - mxi) * (mxa - mxi) + (mya - myi) * (mya - myi);
      if (d2 <= (2 * R) * (2 * R)) begin mest = 2; mperdeu = 1; end
      else if (mpontos < 65535) mpontos++;
    end
  endtask

  // Compare process: outputs against the model once per frame, after the frame settles.
  always @(negedge clk) begin
    if (amostra) begin
      cmp("x_aliada", int'(bolas.x_bola_aliada), mxa);
      cmp("y_aliada", int'(bolas.y_bola_aliada), mya);
      cmp("x_inimiga", int'(bolas.x_bola_inimiga), mxi);
      cmp("y_inimiga", int'(bolas.y_bola_inimiga), myi);
      cmp("raio_aliada", int'(bolas.raio_bola_aliada), R);
      cmp("raio_inimiga", int'(bolas.raio_bola_inimiga), R);
      cmp("perdeu", int'(bolas.perdeu), mperdeu);
      cmp("pontos", int'(bolas.pontos), mpontos);
    end
  end

  task automatic quadro();
    @(posedge clk); #1;
    VGA_X = 10'd0; VGA_Y = 10'd480;
    repeat (2) @(posedge clk); #1;
    VGA_X = 10'd8; VGA_Y = 10'd100;
    repeat (6) @(posedge clk); #1;
    modelo_quadro();
    amostra = 1'b1;
    @(posedge clk); #1;
    amostra = 1'b0;
  endtask

  task automatic quadros(input int n);
    for (int i = 0; i < n; i++) quadro();
  endtask

  task automatic teclas(input logic [3:0] k);
    @(posedge clk); #1;
    if ((|k) && !(|keysout)) begin
      if (mest == 0) mest = 1;
      else if (mest == 2) modelo_inicio();
    end
    keysout = k;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic lit_pos(input string tag, input int xa, input int ya, input int xi, input int yi);
    cmp({tag, "_xa"}, int'(bolas.x_bola_aliada), xa);
    cmp({tag, "_ya"}, int'(bolas.y_bola_aliada), ya);
    cmp({tag, "_xi"}, int'(bolas.x_bola_inimiga), xi);
    cmp({tag, "_yi"}, int'(bolas.y_bola_inimiga), yi);
  endtask

  task automatic lit_estado(input string tag, input int perdeu, input int pontos);
    cmp({tag, "_perdeu"}, int'(bolas.perdeu), perdeu);
    cmp({tag, "_pontos"}, int'(bolas.pontos), pontos);
  endtask

  initial begin
    reset = 1'b0; keysout = 4'd0; VGA_X = 10'd8; VGA_Y = 10'd100; amostra = 1'b0;
    modelo_inicio();
    repeat (3) @(posedge clk); #1;
    lit_pos("reset", 300, 300, 500, 100);
    lit_estado("reset", 0, 0);
    cmp("reset_raio", int'(bolas.raio_bola_aliada), 5);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    quadros(3);
    lit_pos("espera", 300, 300, 500, 100);

    teclas(4'b0001);
    quadros(10);
    lit_pos("dir10", 320, 300, 510, 90);
    lit_estado("dir10", 0, 10);

    teclas(4'b0011);
    quadros(84);
    lit_pos("opostas", 320, 300, 594, 6);
    quadro();
    lit_pos("borda_y5", 320, 300, 595, 5);
    quadro();
    lit_pos("clamp_y", 320, 300, 596, 5);
    quadro();
    lit_pos("volta_y", 320, 300, 597, 6);

    teclas(4'b0010);
    quadros(200);
    cmp("clamp_x5", int'(bolas.x_bola_aliada), 5);

    // Async reset inside the CHECK cycle of a frame.
    @(posedge clk); #1;
    VGA_X = 10'd0; VGA_Y = 10'd480;
    repeat (2) @(posedge clk); #1;
    VGA_X = 10'd8; VGA_Y = 10'd100;
    @(posedge clk);
    @(posedge clk); #2;
    keysout = 4'd0;
    reset = 1'b0;
    #1;
    lit_pos("rst_check", 300, 300, 500, 100);
    lit_estado("rst_check", 0, 0);
    modelo_inicio();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    quadro();

    teclas(4'b1001);
    quadros(111);
    teclas(4'b0001);
    quadros(40);
    teclas(4'b0011);
    quadros(9);
    lit_estado("pre_colisao", 0, 160);
    quadro();
    lit_pos("colisao", 602, 78, 608, 70);
    lit_estado("colisao", 1, 160);
    quadros(3);
    lit_estado("congelado", 1, 160);
    lit_pos("congelado", 602, 78, 608, 70);

    teclas(4'b0000);
    teclas(4'b0100);
    lit_pos("recomeco", 300, 300, 500, 100);
    lit_estado("recomeco", 0, 0);
    quadros(2);

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end
endmodule

// File: doc/controle_bolas.md
# controle_bolas

Game-state engine that writes the ball positions the `memory` renderer reads. Once per video frame, during vertical blank, it moves the allied ball from debounced key levels and moves the enemy ball by bouncing it off the screen edges. It then runs a circle-overlap collision test and drives `perdeu` and a survival score. It sits between `keys`/`vga` and `memory` in `projeto`, replacing the constant ball wires.

## Interface
Parameters:
- `H_ATIVO`, 640: visible width in pixels.
- `V_ATIVO`, 480: visible height in pixels.
- `RAIO`, 5: radius of both balls.
- `PASSO_ALIADA`, 2: allied step, in pixels per frame.
- `PASSO_INIMIGA`, 1: initial enemy step per axis, in pixels per frame.

Ports:
- `CLOCK_50` in 1: sole clock, 50 MHz.
- `reset` in 1: asynchronous, active-low; top level drives `~SW[0]`.
- `keysout` in 4: debounced key levels, 1 = pressed. [0] right, [1] left, [2] down, [3] up.
- `VGA_X` in 10: current scan column from `vga`.
- `VGA_Y` in 10: current scan row from `vga`.
- `x_bola_aliada` out 10: allied centre X.
- `y_bola_aliada` out 10: allied centre Y.
- `raio_bola_aliada` out 10: allied radius, constant `RAIO`.
- `x_bola_inimiga` out 10: enemy centre X.
- `y_bola_inimiga` out 10: enemy centre Y.
- `raio_bola_inimiga` out 10: enemy radius, constant `RAIO`.
- `perdeu` out 1: collision latched, game over.
- `pontos` out 16: frames survived, saturating.

## Operation
- Frame tick:
  - `vblank = (VGA_X==0 && VGA_Y==V_ATIVO)`, registered.
  - `tick` is a 1-cycle pulse on the rising edge of `vblank`, i.e. once per frame regardless of the 2:1 pixel-clock ratio.
- Game FSM `estado`:
  - ESPERA:
    - Positions held at start values.
    - A rising edge of `|keysout` moves to JOGANDO.
  - JOGANDO: on every `tick`, runs the frame sub-sequence MOVE then CHECK.
    - If CHECK finds a collision, go to PERDEU and set `perdeu=1`.
  - PERDEU:
    - Positions and `pontos` are frozen.
    - A rising edge of `|keysout` moves to ESPERA, restores start positions and enemy velocity, clears `perdeu`, and zeroes `pontos`.
    - A key held across the collision does not restart; release is required first.
- Allied move, per axis:
  - Opposite keys pressed together, or no key pressed: no motion.
  - Otherwise add or subtract `PASSO_ALIADA`.
  - Clamp to [`RAIO`, `H_ATIVO-1-RAIO`] for X and [`RAIO`, `V_ATIVO-1-RAIO`] for Y.
  - Compute in 11-bit signed so underflow is detected before clamping.
- Enemy move, per axis:
  - Next position = position + velocity.
  - If next position is outside the clamp range, clamp it to the bound and negate that axis velocity in the same cycle.
  - A corner hit negates both axes.
- Collision:
  - `dx=|xa-xi|`, `dy=|ya-yi|` (10 b).
  - Collision when `dx²+dy²` (21 b) ≤ `(2·RAIO)²`. Touching counts as a hit.
- `pontos`:
  - Increments by 1 in CHECK when there is no collision.
  - Saturates at 16'hFFFF.
- Reset values:
  - Allied ball at (300,300); enemy ball at (500,100).
  - Enemy velocity (+`PASSO_INIMIGA`, −`PASSO_INIMIGA`).
  - Radii = `RAIO`, `perdeu=0`, `pontos=0`, `estado`=ESPERA, `tick`=0.

## Timing
- Cycle T: `vblank` becomes true.
- T+1: `tick` asserted.
- T+2: MOVE; new positions appear on the outputs.
- T+3: CHECK; `perdeu` and `pontos` update.
- All outputs are registered and change only in vertical blank, so the renderer never sees a mid-frame update.
- Key press to start: ESPERA→JOGANDO one cycle after the rising edge of `|keysout`. The first motion happens at the next `tick`.
- `tick` while in ESPERA or PERDEU: ignored.
- Key edge during MOVE or CHECK: the state change takes effect after CHECK completes, never mid-sequence.
- Async reset mid-sequence: all state returns immediately to reset values. The first `tick` after release is honoured normally.

## Configuration
- `ACELERA_INIMIGA_EN` defined:
  - 9-bit frame counter in JOGANDO.
  - Every 512 surviving frames the enemy speed magnitude increases by 1 per axis, keeping sign, up to 4.
  - Speed resets to `PASSO_INIMIGA` on return to ESPERA.
- Undefined: enemy speed stays constant at `PASSO_INIMIGA`; the counter is not instantiated.

## Structure
- Shared package `jogo_pkg`:
  - FSM state enum (ESPERA, JOGANDO, PERDEU).
  - Frame sub-step enum (OCIOSO, MOVE, CHECK).
  - Start coordinates (300,300) and (500,100).
  - Screen constants 640/480.
- Sub-module `colisao_circ`:
  - Combinational-in, registered-out squared-distance comparator.
  - Ports: centres and radii in, `hit` out.
  - Reusable by future projectile logic.

## Test plan
- Reset, then hold `keysout`=0 for 3 frames: positions stay (300,300)/(500,100), `perdeu`=0, `pontos`=0.
- Press key0 to start, then hold key0 for 10 frames:
  - `x_bola_aliada`=320; `y_bola_aliada`=300.
  - Enemy at (510,90); `pontos`=10.
- Hold key1 from x=300 for 200 frames: `x_bola_aliada` clamps at 5, no wrap. Hold key0+key1 together: no change.
- Place the enemy so that it reaches Y=`RAIO` on the next frame: it clamps at Y=5, its Y velocity flips to positive, and X continues unchanged.
- Drive the allied ball onto the enemy path so that dx=6, dy=8 (distance 10):
  - `perdeu`=1 at T+3 and `pontos` frozen.
  - Release, then press a key: ESPERA with positions restored and `perdeu`=0.
- Assert reset during CHECK: all outputs return to reset values asynchronously in the same cycle.
- With `ACELERA_INIMIGA_EN`, after 512 frames the enemy step becomes 2.
